stk_spill_ram_ctrl: RTL and testbench

Slave side of the stack spill/fill interface (StkRamIf). Accepts burst spill writes and fill reads from the stack register cache and drives a single-port synchronous SRAM macro holding the spilled stack entries. Arbitrates the one RAM port between writes and reads, returns read data with a fixed-latency ack, and protects each entry with a parity bit.

---
 rtl/stk_spill_ram_ctrl_if.sv | 28 ++
 rtl/stk_spill_ram_ctrl.sv | 95 +++++++++
 tb/tb_stk_spill_ram_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stk_spill_ram_ctrl_if.sv
// Stack spill/fill request bus between the register cache (master) and the
// spill RAM controller (slave).
interface stk_spill_ram_ctrl_if #(
  parameter int DW = 98,
  parameter int AW = 5
);
  logic          wr_vld;
  logic [AW-1:0] wr_adr;
  logic [DW-1:0] wr_dat;
  logic          wr_rdy;
  logic          rd_vld;
  logic [AW-1:0] rd_adr;
  logic          rd_rdy;
  logic          rd_ack;
  logic [DW-1:0] rd_dat;
  logic [AW-1:0] rd_ack_adr;
  logic          rd_perr;

  modport master (
    output wr_vld, wr_adr, wr_dat, rd_vld, rd_adr,
    input  wr_rdy, rd_rdy, rd_ack, rd_dat, rd_ack_adr, rd_perr
  );

  modport slave (
    input  wr_vld, wr_adr, wr_dat, rd_vld, rd_adr,
    output wr_rdy, rd_rdy, rd_ack, rd_dat, rd_ack_adr, rd_perr
  );
endinterface

// File: rtl/stk_spill_ram_ctrl.sv
// Spill/fill controller for a single-port stack SRAM: write/read ping-pong
// arbitration, fixed-latency read acks, per-entry even parity.
module stk_spill_ram_ctrl #(
  parameter int DW        = 98,
  parameter int AW        = 5,
  parameter int RAM_DEPTH = 24,
  parameter int RD_LAT    = 1,
  parameter int PARITY_EN = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  stk_spill_ram_ctrl_if.slave     sif,
  output logic [1:0]              err_sticky,
  input  logic                    ram_busy,
  output logic                    ram_cs,
  output logic                    ram_we,
  output logic [AW-1:0]           ram_addr,
  output logic [DW+PARITY_EN-1:0] ram_wdata,
  input  logic [DW+PARITY_EN-1:0] ram_rdata
);

  localparam logic [AW:0] DEPTH = (AW+1)'(RAM_DEPTH);

  logic                   g;
  logic                   wr_acc;
  logic                   rd_acc;
  logic                   wr_oor;
  logic                   rd_oor;
  logic                   pref_wr;
  logic                   par_bad;
  logic                   ack_oor;
  logic [RD_LAT-1:0]      pv;
  logic [RD_LAT-1:0]      po;
  logic [RD_LAT-1:0][AW-1:0] pa;

  assign g      = rst_n && !ram_busy && !clear;
  assign wr_oor = {1'b0, sif.wr_adr} >= DEPTH;
  assign rd_oor = {1'b0, sif.rd_adr} >= DEPTH;

  // grants look only at the competing request, never the requester's own vld
  assign sif.wr_rdy = g && (!sif.rd_vld || pref_wr);
  assign sif.rd_rdy = g && (!sif.wr_vld || !pref_wr);
  assign wr_acc     = sif.wr_vld && sif.wr_rdy;
  assign rd_acc     = sif.rd_vld && sif.rd_rdy;

  assign ram_cs   = (wr_acc && !wr_oor) || (rd_acc && !rd_oor);
  assign ram_we   = wr_acc && !wr_oor;
  assign ram_addr = wr_acc ? sif.wr_adr : sif.rd_adr;

  if (PARITY_EN != 0) begin : g_par
    assign ram_wdata = {^sif.wr_dat, sif.wr_dat};
  end else begin : g_nopar
    assign ram_wdata = sif.wr_dat;
  end

  assign par_bad        = (PARITY_EN != 0) && (^ram_rdata);
  assign ack_oor        = po[RD_LAT-1];
  assign sif.rd_ack     = pv[RD_LAT-1] && !clear;
  assign sif.rd_ack_adr = pa[RD_LAT-1];
  assign sif.rd_dat     = (sif.rd_ack && !ack_oor) ? ram_rdata[DW-1:0] : '0;
  assign sif.rd_perr    = sif.rd_ack && !ack_oor && par_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv         <= '0;
      po         <= '0;
      pa         <= '0;
      pref_wr    <= 1'b1;
      err_sticky <= 2'b00;
    end else if (clear) begin
      pv         <= '0;
      pref_wr    <= 1'b1;
      err_sticky <= 2'b00;
    end else begin
      pv[0] <= rd_acc;
      po[0] <= rd_oor;
      pa[0] <= sif.rd_adr;
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        po[i] <= po[i-1];
        pa[i] <= pa[i-1];
      end
      if (wr_acc)
        pref_wr <= 1'b0;
      else if (rd_acc)
        pref_wr <= 1'b1;
      if (sif.rd_perr)
        err_sticky[0] <= 1'b1;
      if ((wr_acc && wr_oor) || (rd_acc && rd_oor))
        err_sticky[1] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stk_spill_ram_ctrl.sv
// Directed scoreboard bench: RD_LAT=1 instance for the main flows, a second
// RD_LAT=2 instance for flushing reads in flight.
module tb_stk_spill_ram_ctrl;

  localparam int DW = 98;
  localparam int AW = 5;
  localparam int RW = DW + 1;

  typedef struct {
    int            cyc;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic          perr;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stk_spill_ram_ctrl_if #(.DW(DW), .AW(AW)) bus1 ();
  stk_spill_ram_ctrl_if #(.DW(DW), .AW(AW)) bus2 ();

  logic          clear1, busy1, cs1, we1;
  logic [1:0]    err1;
  logic [AW-1:0] addr1;
  logic [RW-1:0] wdata1, rdata1, rq1;
  logic [RW-1:0] mem1 [0:31];
  logic          flip;

  logic          clear2, busy2, cs2, we2;
  logic [1:0]    err2;
  logic [AW-1:0] addr2;
  logic [RW-1:0] wdata2, rdata2, rq2a, rq2b;
  logic [RW-1:0] mem2 [0:31];

  stk_spill_ram_ctrl dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear1), .sif(bus1.slave),
    .err_sticky(err1), .ram_busy(busy1), .ram_cs(cs1), .ram_we(we1),
    .ram_addr(addr1), .ram_wdata(wdata1), .ram_rdata(rdata1)
  );

  stk_spill_ram_ctrl #(.RD_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear2), .sif(bus2.slave),
    .err_sticky(err2), .ram_busy(busy2), .ram_cs(cs2), .ram_we(we2),
    .ram_addr(addr2), .ram_wdata(wdata2), .ram_rdata(rdata2)
  );

  // SRAM macro models
  always @(posedge clk) begin
    if (cs1) begin
      if (we1) mem1[addr1] <= wdata1;
      else     rq1 <= mem1[addr1];
    end
  end
  assign rdata1 = rq1 ^ {flip, {DW{1'b0}}};

  always @(posedge clk) begin
    if (cs2 && we2)  mem2[addr2] <= wdata2;
    if (cs2 && !we2) rq2a <= mem2[addr2];
    rq2b <= rq2a;
  end
  assign rdata2 = rq2b;

  int            n_tot = 0;
  int            n_pass = 0;
  int            n_fail = 0;
  int            cyc = 0;
  logic          pref_m;
  logic [DW-1:0] shadow [0:31];
  sb_t           sb [$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_dat();
    return {2'b10, $urandom(), $urandom(), $urandom()};
  endfunction

  // One clock cycle on dut1: drive, check grants/RAM strobes/acks, update model.
  task automatic do_cycle(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                          input logic rv, input logic [AW-1:0] ra,
                          input logic clr, input logic busy);
    logic g, ew, er, ok;
    sb_t  e;
    bus1.wr_vld = wv; bus1.wr_adr = wa; bus1.wr_dat = wd;
    bus1.rd_vld = rv; bus1.rd_adr = ra;
    clear1 = clr; busy1 = busy;
    g  = !busy && !clr;
    ew = g && (!rv || pref_m);
    er = g && (!wv || !pref_m);
    @(negedge clk);
    if (clr) begin
      chk("ack_in_clear", 128'(bus1.rd_ack), 128'(0));
      sb.delete();
    end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      chk("ack", 128'(bus1.rd_ack), 128'(1));
      chk("ack_adr", 128'(bus1.rd_ack_adr), 128'(e.adr));
      chk("ack_dat", 128'(bus1.rd_dat), 128'(e.dat));
      chk("ack_perr", 128'(bus1.rd_perr), 128'(e.perr));
    end else begin
      chk("no_ack", 128'(bus1.rd_ack), 128'(0));
    end
    chk("wr_rdy", 128'(bus1.wr_rdy), 128'(ew));
    chk("rd_rdy", 128'(bus1.rd_rdy), 128'(er));
    if (wv && ew) begin
      ok = (wa < 24);
      chk("wr_cs", 128'(cs1), 128'(ok));
      chk("wr_we", 128'(we1), 128'(ok));
      if (ok) begin
        chk("wr_addr", 128'(addr1), 128'(wa));
        chk("wr_wdata", 128'(wdata1), 128'({^wd, wd}));
        shadow[wa] = wd;
      end
      pref_m = 1'b0;
    end else if (rv && er) begin
      ok = (ra < 24);
      chk("rd_cs", 128'(cs1), 128'(ok));
      chk("rd_we", 128'(we1), 128'(0));
      if (ok) chk("rd_addr", 128'(addr1), 128'(ra));
      e.cyc  = cyc + 1;
      e.adr  = ra;
      e.dat  = ok ? shadow[ra] : '0;
      e.perr = ok && flip;
      sb.push_back(e);
      pref_m = 1'b1;
    end else begin
      chk("idle_cs", 128'(cs1), 128'(0));
    end
    if (clr) pref_m = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle();
    do_cycle(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [AW-1:0] k;
    logic [DW-1:0] d2;
    rst_n = 1'b0;
    flip = 1'b0;
    pref_m = 1'b1;
    clear1 = 1'b0; busy1 = 1'b0; clear2 = 1'b0; busy2 = 1'b0;
    bus1.wr_vld = 1'b1; bus1.wr_adr = 5'd1; bus1.wr_dat = '0;
    bus1.rd_vld = 1'b1; bus1.rd_adr = 5'd1;
    bus2.wr_vld = 1'b0; bus2.wr_adr = '0; bus2.wr_dat = '0;
    bus2.rd_vld = 1'b0; bus2.rd_adr = '0;

    #12;
    chk("rst_wr_rdy", 128'(bus1.wr_rdy), 128'(0));
    chk("rst_rd_rdy", 128'(bus1.rd_rdy), 128'(0));
    chk("rst_cs", 128'(cs1), 128'(0));
    chk("rst_we", 128'(we1), 128'(0));
    chk("rst_ack", 128'(bus1.rd_ack), 128'(0));
    chk("rst_perr", 128'(bus1.rd_perr), 128'(0));
    chk("rst_ack_adr", 128'(bus1.rd_ack_adr), 128'(0));
    chk("rst_err", 128'(err1), 128'(0));
    bus1.wr_vld = 1'b0; bus1.rd_vld = 1'b0;
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // both requesters active: W,R,W,R,W,R starting with the write
    for (int i = 0; i < 6; i++) begin
      k = 5'(8 + i/2);
      do_cycle(1'b1, k, rnd_dat(), 1'b1, k, 1'b0, 1'b0);
    end
    idle();

    for (int i = 0; i < 4; i++) do_cycle(1'b1, 5'(4+i), DW'(160+i), 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) do_cycle(1'b0, '0, '0, 1'b1, 5'(4+i), 1'b0, 1'b0);
    idle();

    // out-of-range write and read
    do_cycle(1'b1, 5'd30, rnd_dat(), 1'b0, '0, 1'b0, 1'b0);
    chk("err_oor", 128'(err1), 128'(2'b10));
    do_cycle(1'b0, '0, '0, 1'b1, 5'd25, 1'b0, 1'b0);
    idle();

    // corrupted parity bit on readback, then clear
    do_cycle(1'b1, 5'd3, rnd_dat(), 1'b0, '0, 1'b0, 1'b0);
    flip = 1'b1;
    do_cycle(1'b0, '0, '0, 1'b1, 5'd3, 1'b0, 1'b0);
    idle();
    chk("err_par", 128'(err1), 128'(2'b11));
    flip = 1'b0;
    do_cycle(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    chk("err_clear", 128'(err1), 128'(0));

    // ram_busy stalls the write while an in-flight read still acks
    do_cycle(1'b0, '0, '0, 1'b1, 5'd5, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 5'd12, DW'(98'h5A5), 1'b0, '0, 1'b0, 1'b1);
    do_cycle(1'b1, 5'd12, DW'(98'h5A5), 1'b0, '0, 1'b0, 1'b0);
    do_cycle(1'b0, '0, '0, 1'b1, 5'd12, 1'b0, 1'b0);
    idle();
    chk("sb_drained", 128'(sb.size()), 128'(0));

    // RD_LAT=2 instance
    d2 = rnd_dat();
    bus2.wr_vld = 1'b1; bus2.wr_adr = 5'd2; bus2.wr_dat = d2;
    @(negedge clk);
    chk("l2_wr_rdy", 128'(bus2.wr_rdy), 128'(1));
    chk("l2_wr_cs", 128'(cs2), 128'(1));
    @(posedge clk); #1;
    bus2.wr_vld = 1'b0; bus2.rd_vld = 1'b1; bus2.rd_adr = 5'd2;
    @(negedge clk);
    chk("l2_rd_rdy", 128'(bus2.rd_rdy), 128'(1));
    @(posedge clk); #1;
    bus2.rd_vld = 1'b0;
    @(negedge clk);
    chk("l2_early_ack", 128'(bus2.rd_ack), 128'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("l2_ack", 128'(bus2.rd_ack), 128'(1));
    chk("l2_ack_dat", 128'(bus2.rd_dat), 128'(d2));
    chk("l2_ack_adr", 128'(bus2.rd_ack_adr), 128'(2));
    chk("l2_ack_perr", 128'(bus2.rd_perr), 128'(0));
    @(posedge clk); #1;
    bus2.rd_vld = 1'b1;
    @(negedge clk);
    chk("l2_rd_rdy_t", 128'(bus2.rd_rdy), 128'(1));
    @(posedge clk); #1;
    clear2 = 1'b1;
    @(negedge clk);
    chk("l2_clr_rd_rdy", 128'(bus2.rd_rdy), 128'(0));
    chk("l2_clr_cs", 128'(cs2), 128'(0));
    chk("l2_clr_ack", 128'(bus2.rd_ack), 128'(0));
    @(posedge clk); #1;
    clear2 = 1'b0; bus2.rd_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("l2_flushed_ack", 128'(bus2.rd_ack), 128'(0));
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
